// File: rtl/serial_cfg_pkg.sv
// Shared definitions for the serial configuration bus master.
//   - Frame geometry and write-flag value for the 40-bit write frame.
//   - Serializer state encoding.
//   - Register addresses of the fullchip configuration map.
//   - make_frame(): assembles {write flag, address, data}, MSB first on the wire.
package serial_cfg_pkg;

  localparam int FRAME_BITS = 40;
  localparam logic WRITE_FLAG = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    LOAD,
    GAP
  } cfg_state_e;

  localparam logic [6:0] ADDR_CH1IN_FREQ  = 7'h10;
  localparam logic [6:0] ADDR_CH2IN_FREQ  = 7'h11;
  localparam logic [6:0] ADDR_CH3IN_FREQ  = 7'h12;
  localparam logic [6:0] ADDR_CH4IN_FREQ  = 7'h13;
  localparam logic [6:0] ADDR_CH1OUT_FREQ = 7'h14;
  localparam logic [6:0] ADDR_CH2OUT_FREQ = 7'h15;
  localparam logic [6:0] ADDR_CH3OUT_FREQ = 7'h16;
  localparam logic [6:0] ADDR_CH4OUT_FREQ = 7'h17;
  localparam logic [6:0] ADDR_MISC        = 7'h20;
  localparam logic [6:0] ADDR_RATES       = 7'h21;

  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [6:0]  addr,
                                                       input logic [31:0] data);
    return {WRITE_FLAG, addr, data};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for the serial configuration bus.
//   clk     : clock
//   reset   : synchronous active-high, pointer back to 0
//   req     : request vector
//   advance : commit the current grant; pointer moves past the winner
//   grant   : one-hot winner (combinational)
//   found   : at least one request is set
// The search starts at the pointer and wraps; the pointer only moves when
// the grant is actually taken, so a dropped request is never remembered.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic            found
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_n;

  // Two passes: indices at/above the pointer first, then the wrapped part.
  always_comb begin
    grant = '0;
    found = 1'b0;
    ptr_n = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[k] && (k >= int'(ptr))) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        ptr_n    = (k == NREQ - 1) ? '0 : PW'(k + 1);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[k] && (k < int'(ptr))) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        ptr_n    = (k == NREQ - 1) ? '0 : PW'(k + 1);
      end
    end
  end

  if (NREQ == 1) begin : g_single
    assign ptr = '0;
  end else begin : g_multi
    always_ff @(posedge clk) begin
      if (reset) begin
        ptr <= '0;
      end else if (advance) begin
        ptr <= ptr_n;
      end
    end
  end

endmodule

// File: rtl/serial_cfg_master.sv
// Arbiter + serializer driving the fullchip serial configuration pins.
//   clk_120mhz : clock
//   reset      : synchronous active-high
//   req_valid  : per-requester word pending
//   req_addr   : packed 7-bit addresses, requester i at [7i+6:7i]
//   req_data   : packed 32-bit data, requester i at [32i+31:32i]
//   req_ack    : one-cycle pulse in the cycle the word is latched
//   busy       : high from the cycle after grant until the frame ends
//   SEN        : serial enable, active-low
//   SCLK       : serial clock, idles low, receiver samples on rise
//   SDI        : serial data, MSB first, changes only when SCLK falls
//   SLD        : load strobe, active-high
// Handshake: a requester holds req_valid/addr/data stable until req_ack;
// req_ack is combinational in the grant cycle and the word is taken on that
// clock edge. A req_valid still high after ack counts as a new request.
// Frame timing (H = HALFDIV), counting the grant cycle as cycle 0:
//   SETUP H, SHIFT 80H, HOLD H, LOAD H, GAP H-1 -> next grant at 84H.
// The grant cycle itself is the first cycle of the frame, so GAP is one
// cycle short and grant-to-grant spacing is exactly 84H.
module serial_cfg_master
  import serial_cfg_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int HALFDIV = 4
) (
  input  logic               clk_120mhz,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [7*NREQ-1:0]  req_addr,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    req_ack,
  output logic               busy,
  output logic               SEN,
  output logic               SCLK,
  output logic               SDI,
  output logic               SLD
);

  localparam logic [7:0] DIV_LAST = 8'(HALFDIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(HALFDIV - 2);

  cfg_state_e            state, state_n;
  logic [7:0]            div, div_n;
  logic [5:0]            bitcnt, bit_n;
  logic                  hi, hi_n;
  logic [FRAME_BITS-1:0] shreg, shreg_n;
  logic                  last;
  logic                  advance;
  logic [NREQ-1:0]       grant;
  logic                  found;
  logic [6:0]            sel_addr;
  logic [31:0]           sel_data;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk_120mhz),
    .reset   (reset),
    .req     (req_valid),
    .advance (advance),
    .grant   (grant),
    .found   (found)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[7*i +: 7];
        sel_data = req_data[32*i +: 32];
      end
    end
  end

  // Ack only while idle; suppressed during reset so an aborted cycle never acks.
  assign req_ack = (state == IDLE && !reset) ? grant : '0;
  assign SDI     = shreg[FRAME_BITS-1];
  assign SCLK    = hi;

  always_comb begin
    state_n = state;
    div_n   = div;
    bit_n   = bitcnt;
    hi_n    = hi;
    shreg_n = shreg;
    advance = 1'b0;
    last    = (div == DIV_LAST);
    case (state)
      IDLE: begin
        if (found) begin
          advance = 1'b1;
          shreg_n = make_frame(sel_addr, sel_data);
          div_n   = '0;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (last) begin
          div_n   = '0;
          hi_n    = 1'b0;
          bit_n   = 6'(FRAME_BITS - 1);
          state_n = SHIFT;
        end else begin
          div_n = div + 8'd1;
        end
      end
      SHIFT: begin
        if (!last) begin
          div_n = div + 8'd1;
        end else begin
          div_n = '0;
          if (!hi) begin
            hi_n = 1'b1;
          end else begin
            // End of a high phase: SCLK falls, next bit (if any) goes out.
            hi_n = 1'b0;
            if (bitcnt == 6'd0) begin
              state_n = HOLD;
            end else begin
              bit_n   = bitcnt - 6'd1;
              shreg_n = {shreg[FRAME_BITS-2:0], 1'b0};
            end
          end
        end
      end
      HOLD: begin
        if (last) begin
          div_n   = '0;
          state_n = LOAD;
        end else begin
          div_n = div + 8'd1;
        end
      end
      LOAD: begin
        if (last) begin
          div_n   = '0;
          state_n = (HALFDIV == 1) ? IDLE : GAP;
        end else begin
          div_n = div + 8'd1;
        end
      end
      GAP: begin
        if (div == GAP_LAST) begin
          div_n   = '0;
          state_n = IDLE;
        end else begin
          div_n = div + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Pin outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_120mhz) begin
    if (reset) begin
      state  <= IDLE;
      div    <= '0;
      bitcnt <= '0;
      hi     <= 1'b0;
      shreg  <= '0;
      busy   <= 1'b0;
      SEN    <= 1'b1;
      SLD    <= 1'b0;
    end else begin
      state  <= state_n;
      div    <= div_n;
      bitcnt <= bit_n;
      hi     <= hi_n;
      shreg  <= shreg_n;
      busy   <= (state_n != IDLE);
      SEN    <= !((state_n == SETUP) || (state_n == SHIFT));
      SLD    <= (state_n == LOAD);
    end
  end

endmodule

// File: tb/tb_serial_cfg_master.sv
// Directed bench for serial_cfg_master: one instance at HALFDIV=4, one at
// HALFDIV=1, both NREQ=4, sharing clock and reset.
module tb_serial_cfg_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [3:0]   a_valid, a_ack, b_valid, b_ack;
  logic [27:0]  a_addr, b_addr;
  logic [127:0] a_data, b_data;
  logic a_busy, a_sen, a_sclk, a_sdi, a_sld;
  logic b_busy, b_sen, b_sclk, b_sdi, b_sld;

  serial_cfg_master #(.NREQ(4), .HALFDIV(4)) dut_a (
    .clk_120mhz(clk), .reset(reset), .req_valid(a_valid), .req_addr(a_addr),
    .req_data(a_data), .req_ack(a_ack), .busy(a_busy), .SEN(a_sen),
    .SCLK(a_sclk), .SDI(a_sdi), .SLD(a_sld));

  serial_cfg_master #(.NREQ(4), .HALFDIV(1)) dut_b (
    .clk_120mhz(clk), .reset(reset), .req_valid(b_valid), .req_addr(b_addr),
    .req_data(b_data), .req_ack(b_ack), .busy(b_busy), .SEN(b_sen),
    .SCLK(b_sclk), .SDI(b_sdi), .SLD(b_sld));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ---------------- bus monitors ----------------
  int a_nbits = 0, a_sen_low = 0, a_sld_high = 0, a_sld_pulses = 0;
  int a_sdi_viol = 0, a_multi_ack = 0, a_acks = 0;
  logic [39:0] a_cap = '0;
  logic a_sclk_d = 1'b0, a_sdi_d = 1'b0, a_sen_d = 1'b1, a_sld_d = 1'b0;

  int b_nbits = 0, b_sld_high = 0, b_period_bad = 0, b_last_rise = -1;
  logic [39:0] b_cap = '0;
  logic b_sclk_d = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    a_sclk_d <= a_sclk;
    a_sdi_d  <= a_sdi;
    a_sen_d  <= a_sen;
    a_sld_d  <= a_sld;
    if (a_sclk && !a_sclk_d) begin
      a_cap   <= {a_cap[38:0], a_sdi};
      a_nbits <= a_nbits + 1;
    end
    if (!a_sen) a_sen_low <= a_sen_low + 1;
    if (a_sld) a_sld_high <= a_sld_high + 1;
    if (a_sld && !a_sld_d) a_sld_pulses <= a_sld_pulses + 1;
    if ((a_sdi != a_sdi_d) && !a_sen && !a_sen_d && !(a_sclk_d && !a_sclk))
      a_sdi_viol <= a_sdi_viol + 1;
    if ($countones(a_ack) > 1) a_multi_ack <= a_multi_ack + 1;
    if (a_ack != 4'b0) a_acks <= a_acks + 1;

    b_sclk_d <= b_sclk;
    if (b_sclk && !b_sclk_d) begin
      b_cap   <= {b_cap[38:0], b_sdi};
      b_nbits <= b_nbits + 1;
      if (b_last_rise >= 0 && (cyc - b_last_rise) != 2) b_period_bad <= b_period_bad + 1;
      b_last_rise <= cyc;
    end
    if (b_sld) b_sld_high <= b_sld_high + 1;
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns in the grant cycle (negedge + 1) with the winning index.
  task automatic wait_ack(input bit on_b, input int budget, output int idx, output int at);
    logic [3:0] ack;
    idx = -1;
    at  = -1;
    for (int n = 0; n < budget; n++) begin
      #1;
      ack = on_b ? b_ack : a_ack;
      if (ack != 4'b0) begin
        at = cyc;
        for (int k = 0; k < 4; k++) if (ack[k]) idx = k;
        break;
      end
      @(negedge clk);
    end
    if (idx < 0) check("ack_timeout", 64'(idx), 64'd0);
  endtask

  task automatic wait_idle(input bit on_b, input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #1;
      if (!(on_b ? b_busy : a_busy)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("idle_timeout", 64'(at), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  logic [1:0] exp_q[$];
  int idx, at, t0, prev, nb0, sen0, sld0, pul0, ack0;

  initial begin
    reset   = 1'b1;
    a_valid = 4'b0; a_addr = '0; a_data = '0;
    b_valid = 4'b0; b_addr = '0; b_data = '0;
    repeat (3) @(negedge clk);
    a_valid = 4'b1111;
    #1;
    check("reset_ack", a_ack, 4'b0);
    check("reset_busy", a_busy, 1'b0);
    check("reset_sen", a_sen, 1'b1);
    check("reset_sclk", a_sclk, 1'b0);
    check("reset_sdi", a_sdi, 1'b0);
    check("reset_sld", a_sld, 1'b0);
    check("reset_b_sen", b_sen, 1'b1);
    @(negedge clk);
    a_valid = 4'b0;
    reset   = 1'b0;

    // Single word on requester 0.
    @(negedge clk);
    a_addr[6:0]  = 7'd5;
    a_data[31:0] = 32'h01234567;
    a_valid = 4'b0001;
    nb0 = a_nbits; sen0 = a_sen_low; sld0 = a_sld_high; pul0 = a_sld_pulses;
    wait_ack(1'b0, 10, idx, t0);
    check("single_ack", a_ack, 4'b0001);
    @(negedge clk);
    a_valid = 4'b0;
    #1;
    check("single_ack_pulse", a_ack, 4'b0);
    check("single_busy", a_busy, 1'b1);
    check("single_sen", a_sen, 1'b0);
    check("single_sdi_first", a_sdi, 1'b0);
    wait_idle(1'b0, 400, at);
    check("single_frame_len", 64'(at - t0), 64'd336);
    check("single_bits", 64'(a_nbits - nb0), 64'd40);
    check("single_data", a_cap, 40'h05_01234567);
    check("single_sen_low", 64'(a_sen_low - sen0), 64'd324);
    check("single_sld_high", 64'(a_sld_high - sld0), 64'd4);
    check("single_sld_pulse", 64'(a_sld_pulses - pul0), 64'd1);

    // Round robin from a freshly reset pointer.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    a_addr  = {7'd4, 7'd3, 7'd2, 7'd1};
    a_data  = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    a_valid = 4'b1111;
    exp_q   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    prev    = -1;
    for (int n = 0; n < 6; n++) begin
      wait_ack(1'b0, 400, idx, at);
      check($sformatf("rr_grant%0d", n), 64'(idx), 64'(exp_q.pop_front()));
      if (n > 0) check($sformatf("rr_spacing%0d", n), 64'(at - prev), 64'd336);
      prev = at;
      @(negedge clk);
    end
    a_valid = 4'b0;
    wait_idle(1'b0, 400, at);

    // Pointer is 2: grant req 2 alone -> pointer 3, then skip/wrap.
    a_valid = 4'b0100;
    wait_ack(1'b0, 10, idx, at);
    check("skip_setup", 64'(idx), 64'd2);
    @(negedge clk);
    a_valid = 4'b0110;
    wait_ack(1'b0, 400, idx, at);
    check("skip_wrap_first", 64'(idx), 64'd1);
    @(negedge clk);
    wait_ack(1'b0, 400, idx, at);
    check("skip_wrap_second", 64'(idx), 64'd2);
    @(negedge clk);
    a_valid = 4'b1111;
    wait_ack(1'b0, 400, idx, at);
    check("skip_ptr_ends_3", 64'(idx), 64'd3);
    @(negedge clk);
    a_valid = 4'b0;
    wait_idle(1'b0, 400, at);

    // Late request arriving mid-frame.
    a_valid = 4'b0001;
    wait_ack(1'b0, 10, idx, t0);
    check("late_first", 64'(idx), 64'd0);
    @(negedge clk);
    a_valid = 4'b0;
    repeat (100) @(negedge clk);
    a_valid = 4'b0100;
    #1;
    check("late_no_ack_busy", a_ack, 4'b0);
    wait_ack(1'b0, 400, idx, at);
    check("late_granted", 64'(idx), 64'd2);
    check("late_first_idle", 64'(at - t0), 64'd336);
    @(negedge clk);
    a_valid = 4'b0;
    wait_idle(1'b0, 400, at);

    // Reset in the middle of bit 20.
    a_valid = 4'b0001;
    wait_ack(1'b0, 10, idx, t0);
    check("abort_grant", 64'(idx), 64'd0);
    nb0 = a_nbits;
    @(negedge clk);
    a_valid = 4'b0;
    repeat (158) @(negedge clk);
    #1;
    check("abort_mid_sen", a_sen, 1'b0);
    check("abort_mid_bits", 64'(a_nbits - nb0), 64'd19);
    pul0 = a_sld_pulses;
    ack0 = a_acks;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_sen", a_sen, 1'b1);
    check("abort_sclk", a_sclk, 1'b0);
    check("abort_busy", a_busy, 1'b0);
    check("abort_sld", a_sld, 1'b0);
    check("abort_sdi", a_sdi, 1'b0);
    repeat (400) @(negedge clk);
    check("abort_no_sld", 64'(a_sld_pulses - pul0), 64'd0);
    check("abort_no_ack", 64'(a_acks - ack0), 64'd0);
    a_addr[6:0]  = 7'h21;
    a_data[31:0] = 32'hDEADBEEF;
    a_valid = 4'b0011;
    wait_ack(1'b0, 10, idx, t0);
    check("abort_ptr_zero", 64'(idx), 64'd0);
    nb0  = a_nbits;
    pul0 = a_sld_pulses;
    @(negedge clk);
    a_valid = 4'b0;
    wait_idle(1'b0, 400, at);
    check("fresh_frame_len", 64'(at - t0), 64'd336);
    check("fresh_bits", 64'(a_nbits - nb0), 64'd40);
    check("fresh_data", a_cap, 40'h21_DEADBEEF);
    check("fresh_sld_pulse", 64'(a_sld_pulses - pul0), 64'd1);
    check("sdi_only_on_fall", 64'(a_sdi_viol), 64'd0);
    check("one_ack_per_cycle", 64'(a_multi_ack), 64'd0);

    // HALFDIV=1 instance with the rates word.
    @(negedge clk);
    b_addr[6:0]  = 7'h21;
    b_data[31:0] = {8'd2, 8'd12, 8'h0f, 8'h07};
    b_valid = 4'b0001;
    nb0  = b_nbits;
    sld0 = b_sld_high;
    wait_ack(1'b1, 10, idx, t0);
    check("fast_grant", 64'(idx), 64'd0);
    @(negedge clk);
    b_valid = 4'b0;
    wait_idle(1'b1, 200, at);
    check("fast_frame_len", 64'(at - t0), 64'd84);
    check("fast_bits", 64'(b_nbits - nb0), 64'd40);
    check("fast_data", b_cap, 40'h21_020C0F07);
    check("fast_sclk_period", 64'(b_period_bad), 64'd0);
    check("fast_sld_high", 64'(b_sld_high - sld0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
